// File: rtl/operand_unpacker_if.sv
// Handshake bundle between the operand packing path and the unpacker:
// word-pair input channel plus the unpacked-operand output channel.
interface operand_unpacker_if #(
  parameter int W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   in_rep;
  logic [W:0]       in_cat;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     a_out;
  logic             c_out;
  logic             err_out;

  // master drives word pairs and consumes unpacked operands
  modport master (
    output in_valid, in_rep, in_cat, out_ready,
    input  in_ready, out_valid, a_out, c_out, err_out
  );

  modport slave (
    input  in_valid, in_rep, in_cat, out_ready,
    output in_ready, out_valid, a_out, c_out, err_out
  );
endinterface

// File: rtl/operand_unpacker.sv
// Checks {a,a}/{a,c} word pairs, recovers a and c, and queues them in a small FIFO.
// Define UNPACK_ERR_CNT_EN to build the saturating integrity-error counter.
module operand_unpacker #(
  parameter int W     = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  operand_unpacker_if.slave bus,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = W + 2;

  typedef struct packed {
    logic         err;
    logic         c;
    logic [W-1:0] a;
  } entry_t;

  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  entry_t        head_reg, head_next;

  logic   push, pop, full, empty;
  entry_t in_entry;

  // ---------------- decode ----------------
  logic [W-1:0] hi, lo;
  logic [W-1:0] rep_eq, cat_eq;
  logic         rep_ok, cat_ok;

  assign hi = bus.in_rep[2*W-1:W];
  assign lo = bus.in_rep[W-1:0];

  for (genvar gi = 0; gi < W; gi++) begin : g_cmp
    assign rep_eq[gi] = hi[gi] ~^ lo[gi];
    assign cat_eq[gi] = bus.in_cat[gi+1] ~^ lo[gi];
  end

  assign rep_ok = &rep_eq;
  assign cat_ok = &cat_eq;

  always_comb begin
    in_entry     = '0;
    in_entry.a   = lo;
    in_entry.c   = bus.in_cat[0];
    in_entry.err = !(rep_ok && cat_ok);
  end

  // ---------------- FIFO control ----------------
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // Readiness is a function of registered occupancy only, so a pop in the
  // same cycle never opens a slot for a push into a full FIFO.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;

  assign push = bus.in_valid && !full;
  assign pop  = bus.out_ready && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg + CW'(push) - CW'(pop);
    if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
  end

  // The next head is the word arriving this cycle when it lands in the slot
  // the read pointer moves to; otherwise it is already in the array.
  always_comb begin
    head_next = head_reg;
    if (count_next != '0) begin
      if (push && (rd_ptr_next == wr_ptr_reg))
        head_next = in_entry;
      else
        head_next = entry_t'(mem[rd_ptr_next]);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign bus.a_out   = head_reg.a;
  assign bus.c_out   = head_reg.c;
  assign bus.err_out = head_reg.err;

  // ---------------- error counter ----------------
`ifdef UNPACK_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic             err_push;

  assign err_push = push && in_entry.err;

  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (err_clr)
      err_cnt_next = err_push ? CNT_W'(1) : '0;
    else if (err_push && (err_cnt_reg != {CNT_W{1'b1}}))
      err_cnt_next = err_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_reg <= '0;
    else        err_cnt_reg <= err_cnt_next;
  end

  assign err_cnt = err_cnt_reg;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule
